id_stage_hazard: RTL

//  Parametrised decode stage with an integrated ID/EX pipeline register.

---
 rtl/id_stage_hazard.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_hazard.sv
// Decode stage with integrated ID/EX register: RF with WB bypass, control decode,
// immediate extension and load-use hazard detection.
module id_stage_hazard #(
    parameter int NB     = 32,
    parameter int REGS   = 5,
    parameter int NREG   = 32,
    parameter int INBITS = 16,
    parameter int CTRLNB = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_step,
    input  logic              i_valid,
    input  logic [NB-1:0]     i_instruction,
    input  logic [NB-1:0]     i_pc4,
    input  logic              i_flush,
    input  logic              i_wb_reg_write,
    input  logic [REGS-1:0]   i_wb_reg_dir,
    input  logic [NB-1:0]     i_wb_data,
    input  logic [REGS-1:0]   i_dbg_reg,
    output logic [NB-1:0]     o_dbg_data,
    output logic              o_stall,
    output logic              o_illegal,
    output logic              o_valid,
    output logic [NB-1:0]     o_data_a,
    output logic [NB-1:0]     o_data_b,
    output logic [NB-1:0]     o_imm,
    output logic [NB-1:0]     o_shamt,
    output logic [CTRLNB-1:0] o_opcode,
    output logic [CTRLNB-1:0] o_funct,
    output logic [REGS-1:0]   o_rs,
    output logic [REGS-1:0]   o_rt,
    output logic [REGS-1:0]   o_reg_dst,
    output logic              o_alu_src,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_mem_to_reg,
    output logic              o_reg_write,
    output logic              o_branch,
    output logic              o_jump,
    output logic              o_jr,
    output logic [NB-1:0]     o_pc4,
    output logic [NB-1:0]     o_jump_addr
);
    // Handshake: o_valid qualifies the ID/EX contents; o_stall asks IF and IF/ID to hold
    // the presented instruction for one cycle; i_step=0 freezes every state element.

    localparam logic [CTRLNB-1:0] OP_RTYPE = CTRLNB'(6'h00);
    localparam logic [CTRLNB-1:0] OP_LW    = CTRLNB'(6'h23);
    localparam logic [CTRLNB-1:0] OP_SW    = CTRLNB'(6'h2B);
    localparam logic [CTRLNB-1:0] OP_ADDI  = CTRLNB'(6'h08);
    localparam logic [CTRLNB-1:0] OP_ANDI  = CTRLNB'(6'h0C);
    localparam logic [CTRLNB-1:0] OP_ORI   = CTRLNB'(6'h0D);
    localparam logic [CTRLNB-1:0] OP_LUI   = CTRLNB'(6'h0F);
    localparam logic [CTRLNB-1:0] OP_BEQ   = CTRLNB'(6'h04);
    localparam logic [CTRLNB-1:0] OP_BNE   = CTRLNB'(6'h05);
    localparam logic [CTRLNB-1:0] OP_J     = CTRLNB'(6'h02);
    localparam logic [CTRLNB-1:0] OP_JAL   = CTRLNB'(6'h03);
    localparam logic [CTRLNB-1:0] FN_JR    = CTRLNB'(6'h08);
    localparam logic [CTRLNB-1:0] FN_JALR  = CTRLNB'(6'h09);

    typedef struct packed {
        logic              valid;
        logic [NB-1:0]     data_a;
        logic [NB-1:0]     data_b;
        logic [NB-1:0]     imm;
        logic [NB-1:0]     shamt;
        logic [CTRLNB-1:0] opcode;
        logic [CTRLNB-1:0] funct;
        logic [REGS-1:0]   rs;
        logic [REGS-1:0]   rt;
        logic [REGS-1:0]   reg_dst;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic              branch;
        logic              jump;
        logic              jr;
        logic [NB-1:0]     pc4;
        logic [NB-1:0]     jump_addr;
    } id_ex_t;

    logic [NB-1:0]     rf [NREG];
    id_ex_t            ex_q;
    id_ex_t            dec;
    logic              illegal_q;
    logic              known;
    logic              uses_rt;
    logic [CTRLNB-1:0] opcode;
    logic [CTRLNB-1:0] funct;
    logic [REGS-1:0]   rs;
    logic [REGS-1:0]   rt;
    logic [REGS-1:0]   rd;
    logic [INBITS-1:0] imm_f;
    logic [NB-1:0]     imm_sext;
    logic [NB-1:0]     imm_zext;
    logic [NB-1:0]     rd_a;
    logic [NB-1:0]     rd_b;

    assign opcode   = CTRLNB'(i_instruction[31:26]);
    assign funct    = CTRLNB'(i_instruction[5:0]);
    assign rs       = REGS'(i_instruction[25:21]);
    assign rt       = REGS'(i_instruction[20:16]);
    assign rd       = REGS'(i_instruction[15:11]);
    assign imm_f    = i_instruction[INBITS-1:0];
    assign imm_sext = {{(NB-INBITS){imm_f[INBITS-1]}}, imm_f};
    assign imm_zext = NB'(imm_f);

    // Out-of-range and $0 reads win over bypass; otherwise a same-cycle WB write is seen.
    function automatic logic [NB-1:0] rf_read(input logic [REGS-1:0] addr);
        if (addr == '0 || int'(addr) >= NREG) return '0;
        if (i_wb_reg_write && addr == i_wb_reg_dir) return i_wb_data;
        return rf[addr];
    endfunction

    assign rd_a       = rf_read(rs);
    assign rd_b       = rf_read(rt);
    assign o_dbg_data = rf_read(i_dbg_reg);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int k = 0; k < NREG; k++) rf[k] <= '0;
        end else if (i_step && i_wb_reg_write && i_wb_reg_dir != '0 && int'(i_wb_reg_dir) < NREG) begin
            rf[i_wb_reg_dir] <= i_wb_data;
        end
    end

    always_comb begin
        dec           = '0;
        known         = 1'b1;
        uses_rt       = 1'b0;
        dec.valid     = 1'b1;
        dec.data_a    = rd_a;
        dec.data_b    = rd_b;
        dec.imm       = imm_sext;
        dec.shamt     = NB'(i_instruction[10:6]);
        dec.opcode    = opcode;
        dec.funct     = funct;
        dec.rs        = rs;
        dec.rt        = rt;
        dec.pc4       = i_pc4;
        dec.jump_addr = {i_pc4[NB-1:28], i_instruction[25:0], 2'b00};
        case (opcode)
            OP_RTYPE: begin
                dec.reg_dst   = rd;
                dec.reg_write = 1'b1;
                uses_rt       = 1'b1;
                if (funct == FN_JR) begin
                    dec.jr        = 1'b1;
                    dec.reg_write = 1'b0;
                end else if (funct == FN_JALR) begin
                    dec.jr = 1'b1;
                end
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.reg_dst    = rt;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                uses_rt       = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.reg_dst   = rt;
                if (opcode == OP_ANDI || opcode == OP_ORI) dec.imm = imm_zext;
                if (opcode == OP_LUI) dec.imm = imm_zext << 16;
            end
            OP_BEQ, OP_BNE: begin
                dec.branch = 1'b1;
                uses_rt    = 1'b1;
            end
            OP_J: dec.jump = 1'b1;
            OP_JAL: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.reg_dst   = REGS'(31);
            end
            default: known = 1'b0;
        endcase
    end

    // rt only counts as a source for formats that actually read it.
    assign o_stall = i_valid && !i_flush && ex_q.valid && ex_q.mem_read && ex_q.reg_dst != '0 &&
                     (ex_q.reg_dst == rs || (uses_rt && ex_q.reg_dst == rt));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ex_q      <= '0;
            illegal_q <= 1'b0;
        end else if (i_step) begin
            if (i_flush || o_stall || !i_valid) begin
                ex_q <= '0;
            end else if (!known) begin
                ex_q      <= '0;
                illegal_q <= 1'b1;
            end else begin
                ex_q <= dec;
            end
        end
    end

    assign o_illegal    = illegal_q;
    assign o_valid      = ex_q.valid;
    assign o_data_a     = ex_q.data_a;
    assign o_data_b     = ex_q.data_b;
    assign o_imm        = ex_q.imm;
    assign o_shamt      = ex_q.shamt;
    assign o_opcode     = ex_q.opcode;
    assign o_funct      = ex_q.funct;
    assign o_rs         = ex_q.rs;
    assign o_rt         = ex_q.rt;
    assign o_reg_dst    = ex_q.reg_dst;
    assign o_alu_src    = ex_q.alu_src;
    assign o_mem_read   = ex_q.mem_read;
    assign o_mem_write  = ex_q.mem_write;
    assign o_mem_to_reg = ex_q.mem_to_reg;
    assign o_reg_write  = ex_q.reg_write;
    assign o_branch     = ex_q.branch;
    assign o_jump       = ex_q.jump;
    assign o_jr         = ex_q.jr;
    assign o_pc4        = ex_q.pc4;
    assign o_jump_addr  = ex_q.jump_addr;

endmodule
